audio_i2s_tx: RTL and testbench

//  Serial audio transmitter to the on-board stereo DAC. It consumes the 16-bit amplitude words

---
 rtl/audio_i2s_tx.sv | 118 +++++++++++
 tb/tb_audio_i2s_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// ---------------------------------------------------------------------------
// audio_i2s_tx
//
// Purpose:
//   Serial audio transmitter for the on-board stereo DAC. Takes 16-bit
//   amplitude words from the volume/tone path, optionally converts them from
//   offset binary to two's complement, and shifts both channels out MSB-first
//   in I2S format (one-bit delay after the LRCK edge). MCLK, SCK and LRCK are
//   all derived from a single free-running divider, so every pin toggles from
//   a flop and the frame timing is fixed relative to reset release.
//
// Parameters:
//   MCLK_DIV_LOG2 - MCLK period is 2^MCLK_DIV_LOG2 clk cycles (1..4)
//   SCK_DIV_LOG2  - SCK period is 2^SCK_DIV_LOG2 clk cycles (> MCLK_DIV_LOG2)
//   OFFSET_BIN    - 1: inputs are offset binary (MSB inverted before sending)
//                   0: inputs are already two's complement
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous reset, active low
//   enable      in   1: transmit the inputs, 0: transmit silence
//   audio_left  in   left-channel amplitude (16 bits)
//   audio_right in   right-channel amplitude (16 bits)
//   sample_req  out  one-clk strobe; inputs are captured on the edge ending it
//   audio_mclk  out  DAC master clock
//   audio_lrck  out  word select, 0 = left slot, 1 = right slot
//   audio_sck   out  serial bit clock
//   audio_sdin  out  serial data, changes on SCK falling edge
// ---------------------------------------------------------------------------
module audio_i2s_tx #(
    parameter int MCLK_DIV_LOG2 = 2,
    parameter int SCK_DIV_LOG2  = 5,
    parameter bit OFFSET_BIN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] audio_left,
    input  logic [15:0] audio_right,
    output logic        sample_req,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin
);

    // One frame is 32 SCK periods, so the divider carries 5 extra bits
    // above the SCK divider; its top 5 bits are the slot number.
    localparam int CNT_W = SCK_DIV_LOG2 + 5;

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [4:0]       slot_next;
    logic             bit_edge;
    logic             frame_end;
    logic [15:0]      shadow_l;
    logic [15:0]      shadow_r;
    logic [31:0]      shift_reg;

    function automatic logic [15:0] conv(input logic [15:0] x);
        if (OFFSET_BIN) begin
            return {~x[15], x[14:0]};
        end else begin
            return x;
        end
    endfunction

    // Output flops are loaded from the *next* divider value so that each pin
    // equals its divider bit in the same cycle while still coming from a flop.
    always_comb begin
        cnt_next  = div_cnt + CNT_W'(1);
        slot_next = cnt_next[CNT_W-1 -: 5];
        bit_edge  = (cnt_next[SCK_DIV_LOG2-1:0] == '0);
        frame_end = (div_cnt == '1);
    end

    // Shift path: the shadow registers are written on the edge that starts
    // slot 0, so they cannot feed the shift register on that same edge. The
    // shift register is therefore loaded at the end of slot 0 (left MSB goes
    // straight to the pin, the remaining 31 bits are queued). Slot 0 itself
    // shifts out the last queued bit, which is the previous right LSB; this
    // gives the I2S one-bit delay without a separate holding flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            sample_req <= 1'b0;
            audio_mclk <= 1'b0;
            audio_sck  <= 1'b0;
            audio_lrck <= 1'b0;
            audio_sdin <= 1'b0;
            shadow_l   <= '0;
            shadow_r   <= '0;
            shift_reg  <= '0;
        end else begin
            div_cnt    <= cnt_next;
            audio_mclk <= cnt_next[MCLK_DIV_LOG2-1];
            audio_sck  <= cnt_next[SCK_DIV_LOG2-1];
            audio_lrck <= cnt_next[CNT_W-1];
            sample_req <= (cnt_next == '1);

            if (frame_end) begin
                shadow_l <= enable ? conv(audio_left)  : 16'h0000;
                shadow_r <= enable ? conv(audio_right) : 16'h0000;
            end

            if (bit_edge) begin
                if (slot_next == 5'd1) begin
                    audio_sdin <= shadow_l[15];
                    shift_reg  <= {shadow_l[14:0], shadow_r, 1'b0};
                end else begin
                    audio_sdin <= shift_reg[31];
                    shift_reg  <= {shift_reg[30:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_audio_i2s_tx
//
// Purpose:
//   Self-checking bench for audio_i2s_tx. A table of input vectors with their
//   expected transmitted words is applied one per frame; expected frames are
//   queued when a capture is seen and compared when the serial decoder has
//   rebuilt a full frame from sdin. A timebase monitor checks MCLK/SCK/LRCK
//   and sample_req against the cycle count since reset release, and a second
//   instance with OFFSET_BIN=0 checks the pass-through conversion.
// ---------------------------------------------------------------------------
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        sample_req, audio_mclk, audio_lrck, audio_sck, audio_sdin;
    logic        req2, mclk2, lrck2, sck2, sdin2;

    typedef struct {
        logic        en;
        logic [15:0] left;
        logic [15:0] right;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        int          delay;
    } vec_t;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } frame_t;

    frame_t exp_q[$];
    vec_t   vecs[8];
    vec_t   rv;
    int     compared   = 0;
    int     mismatched = 0;
    int     cyc        = 0;
    bit     seen;

    logic        prev_sck;
    int          dslot;
    bit          frame_valid;
    logic [15:0] l_acc;
    logic [14:0] r_acc;

    always #5 clk = ~clk;

    audio_i2s_tx #(.MCLK_DIV_LOG2(2), .SCK_DIV_LOG2(5), .OFFSET_BIN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .audio_left(audio_left), .audio_right(audio_right),
        .sample_req(sample_req), .audio_mclk(audio_mclk), .audio_lrck(audio_lrck),
        .audio_sck(audio_sck), .audio_sdin(audio_sdin)
    );

    audio_i2s_tx #(.MCLK_DIV_LOG2(2), .SCK_DIV_LOG2(5), .OFFSET_BIN(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(1'b1),
        .audio_left(16'h8001), .audio_right(16'h7FFF),
        .sample_req(req2), .audio_mclk(mclk2), .audio_lrck(lrck2),
        .audio_sck(sck2), .audio_sdin(sdin2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic failTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got no DUT event, expected one within the cycle budget", name);
    endtask

    task automatic applyStimulus(input vec_t v);
        enable      = v.en;
        audio_left  = v.left;
        audio_right = v.right;
    endtask

    task automatic waitReq(output bit found);
        found = 1'b0;
        for (int i = 0; i < 1200 && !found; i++) begin
            @(negedge clk);
            if (sample_req) found = 1'b1;
        end
        if (!found) failTimeout("sample_req");
    endtask

    task automatic drainQueue();
        for (int i = 0; i < 2500 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) failTimeout("frame_drain");
    endtask

    // Collects the frame following the first capture of the pass-through
    // instance: 33 SCK rising edges = stale slot 0, 16 left bits, 16 right bits.
    task automatic checkDut2();
        bit          found = 1'b0;
        logic [32:0] bits  = '0;
        logic        prev;
        int          n     = 0;
        for (int i = 0; i < 1200 && !found; i++) begin
            @(negedge clk);
            if (req2) found = 1'b1;
        end
        if (!found) begin
            failTimeout("dut2_req");
            return;
        end
        prev = sck2;
        for (int i = 0; i < 1500 && n < 33; i++) begin
            @(negedge clk);
            if (sck2 && !prev) begin
                bits = {bits[31:0], sdin2};
                n++;
            end
            prev = sck2;
        end
        if (n < 33) failTimeout("dut2_bits");
        else checkOutput("raw_twos_comp", bits[31:0], 32'h8001_7FFF);
    endtask

    // Cycle count since reset release; equals the DUT divider at each negedge.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Timebase: mclk = cnt[1], sck = cnt[4], lrck = cnt[9], req at cnt 1023.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("timebase",
                {28'd0, sample_req, audio_mclk, audio_sck, audio_lrck},
                {28'd0, (cyc[9:0] == 10'h3FF), cyc[1], cyc[4], cyc[9]});
        end
    end

    // Serial decoder: samples sdin on SCK rising edges. A frame's right LSB
    // arrives in slot 0 of the following frame, which is when it is compared.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sck    <= 1'b0;
            dslot       <= 0;
            frame_valid <= 1'b0;
        end else begin
            prev_sck <= audio_sck;
            if (audio_sck && !prev_sck) begin
                if (dslot == 0) begin
                    if (frame_valid) begin
                        if (exp_q.size() != 0)
                            checkOutput("frame", {l_acc, r_acc, audio_sdin}, exp_q.pop_front());
                    end else begin
                        checkOutput("slot0_after_reset", {31'd0, audio_sdin}, 32'd0);
                    end
                    frame_valid <= 1'b1;
                end else if (dslot <= 16) begin
                    l_acc <= {l_acc[14:0], audio_sdin};
                end else begin
                    r_acc <= {r_acc[13:0], audio_sdin};
                end
                dslot <= (dslot + 1) % 32;
            end
        end
    end

    initial begin
        vecs[0] = '{1'b1, 16'hF530, 16'h8000, 16'h7530, 16'h0000, 3};
        vecs[1] = '{1'b1, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 3};
        vecs[2] = '{1'b1, 16'h8000, 16'h8001, 16'h0000, 16'h0001, 3};
        vecs[3] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 3};
        vecs[4] = '{1'b0, 16'h1234, 16'hABCD, 16'h0000, 16'h0000, 3};
        vecs[5] = '{1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 8 * 32 + 10};
        vecs[6] = '{1'b1, 16'h9000, 16'h8000, 16'h1000, 16'h0000, 3};
        vecs[7] = '{1'b1, 16'h4321, 16'hC0DE, 16'hC321, 16'h40DE, 3};

        rst_n = 1'b0;
        applyStimulus(vecs[0]);
        fork
            checkDut2();
        join_none

        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("outputs_in_reset",
            {27'd0, sample_req, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'd0);
        rst_n = 1'b1;
        exp_q.push_back('0);

        // Vector 5 holds its inputs until slot 8, so vector 6's change lands
        // mid-frame and must only show up in the frame after.
        for (int i = 0; i < 8; i++) begin
            if (i > 0) applyStimulus(vecs[i]);
            waitReq(seen);
            if (!seen) break;
            exp_q.push_back({vecs[i].exp_l, vecs[i].exp_r});
            repeat (vecs[i].delay) @(posedge clk);
            #1;
        end
        drainQueue();

        // Mid-frame reset at slot 10 with mclk and sck high; the captured
        // data must be discarded and a zero frame sent first.
        rv = '{1'b1, 16'hABCD, 16'h1357, 16'h2BCD, 16'h9357, 3};
        applyStimulus(rv);
        waitReq(seen);
        repeat (1 + 10 * 32 + 26) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_outputs",
            {27'd0, sample_req, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('0);
        waitReq(seen);
        if (seen) exp_q.push_back({rv.exp_l, rv.exp_r});
        drainQueue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
